// File: rtl/dual_step_pkg.sv
// Shared types for the dual-stream counter controller.
// State encoding and event-sum helper.
package dual_step_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Number of events accepted this cycle (0..2)
  function automatic logic [1:0] ev_sum(
    input logic a,
    input logic b
  );
    return {a & b, a ^ b};
  endfunction

endpackage

// File: rtl/dual_step_count_ctrl_if.sv
// Event A/B valid/ready handshake bundle.
// Master offers events, slave accepts them.
interface dual_step_count_ctrl_if;

  logic a_valid;
  logic a_ready;
  logic b_valid;
  logic b_ready;

  modport master (
    output a_valid,
    output b_valid,
    input  a_ready,
    input  b_ready
  );

  modport slave (
    input  a_valid,
    input  b_valid,
    output a_ready,
    output b_ready
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sync clear, add 0..2 per cycle.
// Clamps at all-ones, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] q
);

  logic [W:0] sum;

  // Extra top bit catches overflow past all-ones
  assign sum = {1'b0, q} + {{(W-1){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (sum[W]) begin
      q <= '1;
    end else begin
      q <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/dual_step_count_ctrl.sv
// Session controller: accepts A/B events, strobes the
// downstream counter, ends the session on its carry-out.
module dual_step_count_ctrl
  import dual_step_pkg::*;
#(
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               co,
  dual_step_count_ctrl_if.slave ev,
  output logic               cnt1,
  output logic               cnt2,
  output logic               clr,
  output logic               busy,
  output logic               done,
  output logic [TALLY_W-1:0] ev_tally
);

  state_t     state;
  state_t     state_nx;
  logic       run;
  logic       rdy;
  logic       acc_a;
  logic       acc_b;
  logic [1:0] inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Abort wins over co; start only counts in IDLE
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_RUN;
      S_RUN: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (co) begin
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
    endcase
  end

  assign run        = (state == S_RUN);
  assign rdy        = run & ~co;
  assign ev.a_ready = rdy;
  assign ev.b_ready = rdy;
  assign acc_a      = ev.a_valid & rdy;
  assign acc_b      = ev.b_valid & rdy;

  assign clr  = (state == S_CLEAR);
  assign busy = clr | run;
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt1 <= 1'b0;
      cnt2 <= 1'b0;
    end else begin
      cnt1 <= acc_a;
      cnt2 <= acc_b;
    end
  end

  assign inc = ev_sum(acc_a, acc_b);

  sat_counter #(
    .W(TALLY_W)
  ) u_tally (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (inc),
    .q   (ev_tally)
  );

endmodule

// File: tb/tb_dual_step_count_ctrl.sv
// Directed bench for dual_step_count_ctrl; a second
// instance with TALLY_W=2 runs in lockstep for saturation.
module tb_dual_step_count_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort, co;
  logic cnt1, cnt2, clr, busy, done;
  logic [7:0] tally;
  logic cnt1_s, cnt2_s, clr_s, busy_s, done_s;
  logic [1:0] tally_s;
  int errors = 0;
  int checks = 0;

  dual_step_count_ctrl_if ev ();
  dual_step_count_ctrl_if ev2 ();

  assign ev2.a_valid = ev.a_valid;
  assign ev2.b_valid = ev.b_valid;

  always #5 clk = ~clk;

  dual_step_count_ctrl #(.TALLY_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .co(co), .ev(ev), .cnt1(cnt1), .cnt2(cnt2),
    .clr(clr), .busy(busy), .done(done), .ev_tally(tally)
  );

  dual_step_count_ctrl #(.TALLY_W(2)) dut_s (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .co(co), .ev(ev2), .cnt1(cnt1_s), .cnt2(cnt2_s),
    .clr(clr_s), .busy(busy_s), .done(done_s), .ev_tally(tally_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; co = 1'b0;
    ev.a_valid = 1'b0; ev.b_valid = 1'b0;
    repeat (2) step();
    checks++;
    if ({cnt1, cnt2, clr, busy, done, ev.a_ready, ev.b_ready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 0",
        {cnt1, cnt2, clr, busy, done, ev.a_ready, ev.b_ready});
    end
    checks++;
    if (tally !== 8'd0 || tally_s !== 2'd0) begin
      errors++;
      $display("FAIL reset_tally: got %0d/%0d expected 0/0", tally, tally_s);
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    checks++;
    if (clr !== 1'b1 || busy !== 1'b1 || ev.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle: got clr=%b busy=%b rdy=%b expected 1 1 0", clr, busy, ev.a_ready);
    end
    step();
    checks++;
    if (clr !== 1'b0 || busy !== 1'b1 || ev.a_ready !== 1'b1 || ev.b_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_entry: got clr=%b busy=%b rdy=%b%b expected 0 1 11",
        clr, busy, ev.a_ready, ev.b_ready);
    end
  endtask

  task automatic test_a_only();
    ev.a_valid = 1'b1;
    #1;
    checks++;
    if (cnt1 !== 1'b0) begin
      errors++;
      $display("FAIL a_lag: got cnt1=%b expected 0", cnt1);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (cnt1 !== 1'b1 || cnt2 !== 1'b0 || tally !== 8'(i + 1)) begin
        errors++;
        $display("FAIL a_strobe%0d: got cnt1=%b cnt2=%b tally=%0d expected 1 0 %0d",
          i, cnt1, cnt2, tally, i + 1);
      end
    end
    ev.a_valid = 1'b0;
    step();
    checks++;
    if (cnt1 !== 1'b0 || tally !== 8'd3 || tally_s !== 2'd3) begin
      errors++;
      $display("FAIL a_end: got cnt1=%b tally=%0d/%0d expected 0 3/3", cnt1, tally, tally_s);
    end
  endtask

  task automatic test_both();
    ev.a_valid = 1'b1;
    ev.b_valid = 1'b1;
    step();
    checks++;
    if (cnt1 !== 1'b1 || cnt2 !== 1'b1 || tally !== 8'd5) begin
      errors++;
      $display("FAIL both1: got cnt1=%b cnt2=%b tally=%0d expected 1 1 5", cnt1, cnt2, tally);
    end
    checks++;
    if (tally_s !== 2'd3) begin
      errors++;
      $display("FAIL sat_hold: got tally_s=%0d expected 3", tally_s);
    end
    step();
    checks++;
    if (cnt1 !== 1'b1 || cnt2 !== 1'b1 || tally !== 8'd7 || tally_s !== 2'd3) begin
      errors++;
      $display("FAIL both2: got %b%b tally=%0d/%0d expected 11 7/3", cnt1, cnt2, tally, tally_s);
    end
  endtask

  task automatic test_co();
    co = 1'b1;
    #1;
    checks++;
    if (ev.a_ready !== 1'b0 || ev.b_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL co_ready: got rdy=%b%b busy=%b expected 00 1", ev.a_ready, ev.b_ready, busy);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ev.a_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: got done=%b busy=%b rdy=%b expected 1 0 0", done, busy, ev.a_ready);
    end
    chk("done_strobes", {cnt1, cnt2}, 2'b00);
    co = 1'b0;
    ev.a_valid = 1'b0;
    ev.b_valid = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || tally !== 8'd7) begin
      errors++;
      $display("FAIL idle_back: got done=%b busy=%b tally=%0d expected 0 0 7", done, busy, tally);
    end
  endtask

  task automatic test_ignored();
    co = 1'b1;
    abort = 1'b1;
    ev.a_valid = 1'b1;
    #1;
    chk("idle_ready", ev.a_ready, 1'b0);
    step();
    checks++;
    if (busy !== 1'b0 || cnt1 !== 1'b0 || tally !== 8'd7) begin
      errors++;
      $display("FAIL idle_ignore: got busy=%b cnt1=%b tally=%0d expected 0 0 7", busy, cnt1, tally);
    end
    co = 1'b0;
    ev.a_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_wins", clr, 1'b1);
    step();
    checks++;
    if (busy !== 1'b1 || clr !== 1'b0 || tally !== 8'd0 || tally_s !== 2'd0) begin
      errors++;
      $display("FAIL clear_abort: got busy=%b clr=%b tally=%0d/%0d expected 1 0 0/0",
        busy, clr, tally, tally_s);
    end
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || clr !== 1'b0) begin
      errors++;
      $display("FAIL run_start: got busy=%b clr=%b expected 1 0", busy, clr);
    end
  endtask

  task automatic test_abort();
    abort = 1'b1;
    ev.a_valid = 1'b1;
    co = 1'b1;
    #1;
    chk("abort_co_rdy", ev.a_ready, 1'b0);
    co = 1'b0;
    #1;
    chk("abort_rdy", ev.a_ready, 1'b1);
    step();
    abort = 1'b0;
    ev.a_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt1 !== 1'b1 || tally !== 8'd1) begin
      errors++;
      $display("FAIL abort_exit: got busy=%b done=%b cnt1=%b tally=%0d expected 0 0 1 1",
        busy, done, cnt1, tally);
    end
    step();
    checks++;
    if (done !== 1'b0 || cnt1 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_after: got done=%b cnt1=%b busy=%b expected 0 0 0", done, cnt1, busy);
    end
  endtask

  task automatic test_rst_mid();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    ev.a_valid = 1'b1;
    ev.b_valid = 1'b1;
    step();
    chk("mid_pre", {cnt1, cnt2, tally}, {2'b11, 8'd2});
    rst = 1'b1;
    step();
    checks++;
    if ({cnt1, cnt2, clr, busy, done, ev.a_ready, ev.b_ready} !== 7'b0 || tally !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid: got %b tally=%0d expected 0 0",
        {cnt1, cnt2, clr, busy, done, ev.a_ready, ev.b_ready}, tally);
    end
    rst = 1'b0;
    ev.a_valid = 1'b0;
    ev.b_valid = 1'b0;
    step();
    chk("rst_idle", {busy, cnt1, cnt2}, 3'b000);
  endtask

  initial begin
    test_reset();
    test_start();
    test_a_only();
    test_both();
    test_co();
    test_ignored();
    test_abort();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
